valid_proxy: RTL and testbench
==============================

Name: valid_proxy

Overview:
- Fully registered valid/ready pipeline stage (two-entry skid buffer) between an upstream producer and a downstream consumer.
- Cuts every combinational path between the two sides: up_ready, down_valid and down_data all come from flops.
- Sustains one transfer per cycle, with no loss, duplication or reordering of data words.

Parameters:
- DATA_WIDTH, 8, width of up_data/down_data in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- up_data  input  DATA_WIDTH  upstream payload.
- up_valid  input  1  upstream offers up_data this cycle.
- up_ready  output  1  stage can accept a word this cycle; registered.
- down_data  output  DATA_WIDTH  payload offered downstream; registered.
- down_valid  output  1  down_data is valid; registered.
- down_ready  input  1  downstream accepts down_data this cycle.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Transfer semantics:
  - Push: up_valid && up_ready at a rising edge.
  - Pop: down_valid && down_ready at a rising edge.
  - up_data is ignored whenever up_ready=0.
- Storage: main register (M, drives down_data) and skid register (S).
- States: EMPTY, ONE (M valid), FULL (M and S valid). Encoding is local.
- Outputs are decoded from the state register only:
  - down_valid = (state != EMPTY).
  - up_ready = (state != FULL).
  - down_data = M.
  - No combinational path from up_valid/up_data to down_*, nor from down_ready to up_ready.
- Reset values: state=EMPTY, down_valid=0, up_ready=1, M=0, down_data=0, S=0.
- Transitions:
  - EMPTY, push -> ONE, M<=up_data. No push -> stay in EMPTY.
  - ONE, push && pop -> ONE, M<=up_data (full throughput).
  - ONE, push only -> FULL, S<=up_data, M unchanged.
  - ONE, pop only -> EMPTY.
  - ONE, neither -> hold.
  - FULL, pop -> ONE, M<=S. No push is possible since up_ready=0.
  - FULL, no pop -> hold.
- Latency: a word pushed at edge N is presented on down_data/down_valid after edge N when the stage was EMPTY, or behind older words otherwise.
- Throughput: with down_ready held at 1 and up_valid held at 1, one word is transferred per cycle in steady state.
- Stability: while down_valid=1 and down_ready=0, down_data and down_valid hold unchanged.
- Ordering: strict FIFO; the output sequence equals the accepted input sequence.
- down_ready toggling every cycle: no bubbles beyond those caused by down_ready=0, and never more than 2 words buffered.
- Reset mid-operation: both entries are discarded immediately (asynchronous); outputs go to their reset values without waiting for clk.
- X on up_data while up_valid=0 must not propagate to down_data.

Decomposition:
- Small shared package holds the state enum (EMPTY/ONE/FULL) and the default DATA_WIDTH constant.
- No sub-module is needed. An optional generic data_reg (enable-loaded, async-reset register) may be instantiated for M and S.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 2 words buffered -> down_valid=0, up_ready=1, down_data=0 immediately; first word after reset emerges correctly.
- Streaming: up_valid=1, down_ready=1, inputs 0,1,2,...,9 -> down_data 0..9 on consecutive cycles, one cycle after each push, up_ready never drops.
- Upstream bubbles: up_valid toggling 1/0, down_ready=1, inputs 10..14 -> outputs 10..14 in order, down_valid low in the gap cycles.
- Downstream backpressure: up_valid=1, down_ready toggling each cycle -> up_ready drops only in FULL, and the output sequence stays contiguous with no skip or duplicate.
- Stall/fill: down_ready=0 for 4 cycles with up_valid=1 -> exactly 2 words accepted, then up_ready=0 and down_data stable. Releasing down_ready=1 drains both in order, then streaming resumes.
- Idle then resume: up_valid=0, down_ready=0 for 5 cycles, then both 1 -> state EMPTY during idle, and the next values continue the count without a gap.

Source files
------------

// File: rtl/valid_proxy_pkg.sv
// Shared types and defaults for the valid_proxy skid-buffer stage.
// State encoding and default payload width live here so sub-blocks agree on them.
package valid_proxy_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } vp_state_e;

endpackage : valid_proxy_pkg

// File: rtl/valid_proxy_data_reg.sv
// Enable-loaded data register with asynchronous active-low clear.
// Holds its value whenever en is low, so a stalled word never changes.
module valid_proxy_data_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : valid_proxy_data_reg

// File: rtl/valid_proxy.sv
// Fully registered valid/ready stage built as a two-entry skid buffer.
// up_ready, down_valid and down_data all come straight from flops.
module valid_proxy
    import valid_proxy_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_valid,
    output logic                  up_ready,
    output logic [DATA_WIDTH-1:0] down_data,
    output logic                  down_valid,
    input  logic                  down_ready
);

    vp_state_e             state_d;
    vp_state_e             state_q;
    logic                  up_ready_d;
    logic                  up_ready_q;
    logic                  down_valid_d;
    logic                  down_valid_q;

    logic                  push;
    logic                  pop;
    logic                  m_en;
    logic                  s_en;
    logic [DATA_WIDTH-1:0] m_din;
    logic [DATA_WIDTH-1:0] m_q;
    logic [DATA_WIDTH-1:0] s_q;

    // Handshakes only see registered ready/valid, so no input reaches an output combinationally.
    assign push = up_valid && up_ready_q;
    assign pop  = down_valid_q && down_ready;

    always_comb begin
        state_d = state_q;
        m_en    = 1'b0;
        s_en    = 1'b0;
        m_din   = up_data;
        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_ONE;
                    m_en    = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    m_en = 1'b1;
                end else if (push) begin
                    state_d = ST_FULL;
                    s_en    = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // up_ready is low here, so the only move is S advancing into M.
                if (pop) begin
                    state_d = ST_ONE;
                    m_en    = 1'b1;
                    m_din   = s_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        up_ready_d   = (state_d != ST_FULL);
        down_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            up_ready_q   <= 1'b1;
            down_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            up_ready_q   <= up_ready_d;
            down_valid_q <= down_valid_d;
        end
    end

    valid_proxy_data_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (m_en),
        .d     (m_din),
        .q     (m_q)
    );

    valid_proxy_data_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s_en),
        .d     (up_data),
        .q     (s_q)
    );

    assign up_ready   = up_ready_q;
    assign down_valid = down_valid_q;
    assign down_data  = m_q;

endmodule : valid_proxy

// File: tb/tb_valid_proxy.sv
// Scoreboard bench for valid_proxy: accepted words are queued, emitted words are popped and compared.
module tb_valid_proxy;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] up_data;
    logic         up_valid;
    logic         up_ready;
    logic [W-1:0] down_data;
    logic         down_valid;
    logic         down_ready;

    int           errors;
    int           checks;
    logic [W-1:0] sb[$];
    logic [W-1:0] next_val;

    valid_proxy #(
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

    // Handshakes are stable mid-cycle, so the negedge sees what the next posedge will transfer.
    always @(negedge clk) begin
        logic [W-1:0] exp;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (down_valid && down_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: down_data=%0d emitted, required no output", down_data);
                end else begin
                    exp = sb.pop_front();
                    if (down_data !== exp) begin
                        errors++;
                        $display("FAIL sb_data: down_data=%0d, required %0d", down_data, exp);
                    end
                end
            end
            if (up_valid && up_ready) begin
                sb.push_back(up_data);
            end
        end
    end

    // Drives one cycle; called at posedge+1 and returns at the next posedge+1.
    task automatic cycle(input logic v, input logic r);
        logic acc;
        up_valid   = v;
        down_ready = r;
        up_data    = v ? next_val : 'x;
        acc        = v && up_ready;
        @(posedge clk);
        #1;
        if (acc) next_val++;
    endtask

    task automatic test_reset;
        rst_n      = 1'b1;
        up_valid   = 1'b0;
        down_ready = 1'b0;
        up_data    = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_down_valid: got %b, required 0", down_valid); end
        checks++;
        if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_up_ready: got %b, required 1", up_ready); end
        checks++;
        if (down_data !== '0) begin errors++; $display("FAIL reset_down_data: got %0h, required 0", down_data); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_streaming;
        cycle(1'b1, 1'b1);
        checks++;
        if (down_valid !== 1'b1 || down_data !== 8'd0) begin
            errors++;
            $display("FAIL stream_latency: valid=%b data=%0d, required valid=1 data=0", down_valid, down_data);
        end
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, 1'b1);
            checks++;
            if (up_ready !== 1'b1) begin errors++; $display("FAIL stream_up_ready[%0d]: got %b, required 1", i, up_ready); end
        end
        cycle(1'b0, 1'b1);
        checks++;
        if (down_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: down_valid=%b, required 0", down_valid); end
    endtask

    task automatic test_bubbles;
        checks++;
        if (next_val !== 8'd10) begin errors++; $display("FAIL bubble_start: next=%0d, required 10", next_val); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1);
            checks++;
            if (down_valid !== 1'b1) begin errors++; $display("FAIL bubble_valid[%0d]: got %b, required 1", i, down_valid); end
            cycle(1'b0, 1'b1);
            checks++;
            if (down_valid !== 1'b0) begin errors++; $display("FAIL bubble_gap[%0d]: got %b, required 0", i, down_valid); end
        end
    endtask

    task automatic test_backpressure;
        logic r;
        int   occ;
        r = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, r);
            r   = ~r;
            occ = sb.size();
            checks++;
            if (occ > 2) begin errors++; $display("FAIL bp_occupancy[%0d]: got %0d words, required at most 2", i, occ); end
            checks++;
            if (up_ready !== (occ != 2)) begin errors++; $display("FAIL bp_up_ready[%0d]: got %b, required %b", i, up_ready, occ != 2); end
            checks++;
            if (down_valid !== (occ != 0)) begin errors++; $display("FAIL bp_down_valid[%0d]: got %b, required %b", i, down_valid, occ != 0); end
        end
        repeat (3) cycle(1'b0, 1'b1);
    endtask

    task automatic test_stall_fill;
        logic [W-1:0] held;
        logic [W-1:0] start;
        start = next_val;
        cycle(1'b1, 1'b0);
        held = down_data;
        checks++;
        if (held !== start) begin errors++; $display("FAIL stall_first: down_data=%0d, required %0d", held, start); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (up_ready !== 1'b0) begin errors++; $display("FAIL stall_up_ready[%0d]: got %b, required 0", i, up_ready); end
            checks++;
            if (down_data !== held || down_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%0d, required valid=1 data=%0d", i, down_valid, down_data, held);
            end
        end
        checks++;
        if (next_val - start !== 8'd2) begin errors++; $display("FAIL stall_accepted: got %0d words, required 2", next_val - start); end
        repeat (6) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
    endtask

    task automatic test_idle_resume;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0);
            checks++;
            if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle[%0d]: valid=%b ready=%b, required valid=0 ready=1", i, down_valid, up_ready);
            end
        end
        repeat (5) cycle(1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b1);
    endtask

    task automatic test_reset_midstream;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        checks++;
        if (up_ready !== 1'b0) begin errors++; $display("FAIL mid_full: up_ready=%b, required 0", up_ready); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (down_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, required 0", down_valid); end
        checks++;
        if (up_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b, required 1", up_ready); end
        checks++;
        if (down_data !== '0) begin errors++; $display("FAIL mid_reset_data: got %0h, required 0", down_data); end
        up_valid   = 1'b0;
        down_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1'b1, 1'b1);
        checks++;
        if (down_valid !== 1'b1 || down_data !== next_val - 8'd1) begin
            errors++;
            $display("FAIL mid_first_word: valid=%b data=%0d, required valid=1 data=%0d", down_valid, down_data, next_val - 8'd1);
        end
        repeat (2) cycle(1'b0, 1'b1);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        next_val = '0;
        test_reset();
        @(posedge clk);
        #1;
        test_streaming();
        test_bubbles();
        test_backpressure();
        test_stall_fill();
        test_idle_resume();
        test_reset_midstream();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL final_drain: %0d words left, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_valid_proxy
